sha256_compress: RTL and testbench
==================================

Name: sha256_compress

Overview:
- SHA-256 compression stage. Sits directly downstream of the message-schedule block and consumes its per-cycle 32-bit schedule word W_t.
- Runs the 64 compression rounds on working registers a..h, seeded from a 256-bit chaining value.
- Adds the final working state back into the chaining value and presents a 256-bit intermediate/final digest.
- Multi-block messages are handled by feeding the digest back as the next init_hash.

Parameters:
- W_LENGTH, 64, number of rounds and schedule words per block; round counter width is $clog2(W_LENGTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; all state cleared when low at a clock edge
- start  input  1  begin a block; sampled only in IDLE
- init_hash  input  256  chaining value H0..H7; H0 in [255:224], H7 in [31:0]; sampled on accepted start
- w_valid  input  1  schedule word on w_in is valid
- w_in  input  32  schedule word W_t, supplied in order t = 0..W_LENGTH-1
- w_ready  output  1  block accepts W this cycle; W is consumed when w_valid && w_ready
- busy  output  1  high from accepted start until digest_valid
- round_index  output  $clog2(W_LENGTH)  index t of the next W expected; drives the schedule block's index input
- digest  output  256  H0'..H7', same packing as init_hash
- digest_valid  output  1  one-cycle pulse when digest updates

Behaviour:
- Reset (reset==0 at edge): state=IDLE; a..h, H regs, digest, round_index = 0; w_ready, busy, digest_valid = 0. This applies mid-block: the partial block is discarded and no digest_valid is produced.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - w_ready = 0; busy = 0.
  - start==1: H regs <= init_hash; a..h <= init_hash; round_index <= 0; go to ROUND.
  - w_valid is ignored in IDLE.
- ROUND:
  - w_ready = 1; busy = 1.
  - On w_valid, perform one round with K[round_index] and w_in:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K + W
    - T2 = Σ0(a) + Maj(a,b,c)
    - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
    - round_index++.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25; Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - All additions are mod 2^32; carries are discarded.
  - w_valid==0: hold all state (stall); no limit on stall length.
  - Word accepted with round_index==W_LENGTH-1: go to FINAL; round_index wraps to 0.
- FINAL (1 cycle):
  - w_ready = 0; busy = 1.
  - digest <= {H0+a, ..., H7+h}, each lane mod 2^32; digest_valid <= 1 (registered, visible the next cycle).
  - Go to IDLE.
- digest_valid is high exactly one cycle, in the first IDLE cycle after FINAL. busy drops that same cycle.
- digest holds its value until the next FINAL or reset.
- start during ROUND or FINAL is ignored (not queued).
- start in the cycle digest_valid is high is accepted (back-to-back blocks).
- Latency:
  - Start accepted at cycle N; earliest W0 accepted at N+1; with no stalls, W63 at N+64.
  - FINAL at N+65; digest_valid at N+66.
- Constants K[0..63] are the FIPS 180-4 values; no other constants are stored internally.

Decomposition:
- Package sha256_pkg:
  - K table (64 x 32-bit constant array).
  - Initial hash IV H0..H7.
  - State enum {IDLE, ROUND, FINAL}.
  - Functions rotr32, big_sigma0, big_sigma1, ch, maj. The small sigma functions are shared with the schedule block.
- One sub-module: sha256_round. It is purely combinational: inputs a..h, K, W; outputs next a..h. It is instantiated once and is independently unit-testable.

Test Plan:
- "abc" single block: init_hash = IV; W0=61626380, W1..W14=0, W15=00000018, W16..W63 from the bench reference model, w_valid held high -> digest_valid at start+66 with digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: W0=80000000, others 0 before expansion -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Stalls: "abc" with w_valid randomly deasserted 50% of cycles -> identical digest; round_index advances only on accepted words; digest_valid still a single pulse.
- Reset mid-block: drop reset to 0 after round 30 -> next cycle all outputs 0 and state IDLE. A following clean "abc" run gives the correct digest, with no stale digest_valid.
- start asserted during ROUND at round 10 -> ignored, digest unchanged from the single-start result. start asserted on the digest_valid cycle -> second block accepted; its W0 is accepted on the next cycle.
- Two-block chaining: 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second block init_hash = first digest -> final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, the
// compression FSM state type, the working-register bundle and the bit-mixing
// functions. The small sigma functions are also used by the schedule block.
package sha256_pkg;

   localparam int NUM_ROUNDS = 64;

   localparam logic [31:0] K [0:NUM_ROUNDS-1] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // H0 sits in the top lane, H7 in the bottom lane
   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL
   } state_t;

   // Field a is the most significant lane so the struct packs like init_hash
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // Lane-wise mod 2^32 addition of two packed H0..H7 vectors
   function automatic logic [255:0] add_lanes(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Handshake and data bundle between the schedule source / host and the
// compression stage. The master side supplies start, chaining value and
// schedule words; the slave side is the compression block itself.
interface sha256_compress_if #(
   parameter int W_LENGTH = 64
);

   localparam int IDX_W = $clog2(W_LENGTH);

   logic             start;
   logic [255:0]     init_hash;
   logic             w_valid;
   logic [31:0]      w_in;
   logic             w_ready;
   logic             busy;
   logic [IDX_W-1:0] round_index;
   logic [255:0]     digest;
   logic             digest_valid;

   modport master (
      output start, init_hash, w_valid, w_in,
      input  w_ready, busy, round_index, digest, digest_valid
   );

   modport slave (
      input  start, init_hash, w_valid, w_in,
      output w_ready, busy, round_index, digest, digest_valid
   );

endinterface

// File: rtl/sha256_round.sv
// One SHA-256 compression round as pure combinational logic: takes the
// current working registers a..h plus K_t and W_t, returns the next a..h.
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       cur,
   input  logic [31:0] k,
   input  logic [31:0] w,
   output work_t       nxt
);

   logic [31:0] t1;
   logic [31:0] t2;

   // Form T1/T2 and shift the register file down by one, folding T1 into e and a
   always_comb begin
      t1  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
      t2  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
      nxt = {t1 + t2, cur.a, cur.b, cur.c, cur.d + t1, cur.e, cur.f, cur.g};
   end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression stage. Seeds a..h from the chaining value, consumes one
// schedule word per accepted handshake for W_LENGTH rounds, then adds the
// working state back into the chaining value and pulses digest_valid.
module sha256_compress
   import sha256_pkg::*;
#(
   parameter int W_LENGTH = 64
)
(
   input logic              clock,
   input logic              reset,
   sha256_compress_if.slave bus
);

   localparam int               IDX_W    = $clog2(W_LENGTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W_LENGTH - 1);

   state_t           state;
   state_t           state_next;
   work_t            work;
   work_t            work_next;
   logic [255:0]     h_init;
   logic [255:0]     digest;
   logic [IDX_W-1:0] round_index;
   logic             digest_valid;
   logic             w_ready;
   logic             busy;
   logic             last_word;

   assign last_word = (round_index == LAST_IDX);

   sha256_round u_round (
      .cur (work),
      .k   (K[round_index]),
      .w   (bus.w_in),
      .nxt (work_next)
   );

   // State register; a low reset at the edge forces the block back to IDLE
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs: words are taken only while in ROUND
   always_comb begin
      state_next = state;
      w_ready    = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = ROUND;
            end
         end
         ROUND: begin
            w_ready = 1'b1;
            busy    = 1'b1;
            if (bus.w_valid && last_word) begin
               state_next = FINAL;
            end
         end
         FINAL: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch the chaining value, run one round per accepted word, fold the result on FINAL
   always_ff @(posedge clock) begin
      if (!reset) begin
         work         <= '0;
         h_init       <= '0;
         digest       <= '0;
         round_index  <= '0;
         digest_valid <= 1'b0;
      end else begin
         digest_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  h_init      <= bus.init_hash;
                  work        <= work_t'(bus.init_hash);
                  round_index <= '0;
               end
            end
            ROUND: begin
               if (bus.w_valid) begin
                  work        <= work_next;
                  round_index <= last_word ? '0 : round_index + 1'b1;
               end
            end
            FINAL: begin
               digest       <= add_lanes(h_init, work);
               digest_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.w_ready      = w_ready;
   assign bus.busy         = busy;
   assign bus.round_index  = round_index;
   assign bus.digest       = digest;
   assign bus.digest_valid = digest_valid;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress. A transaction-level SHA-256 model
// collects the accepted schedule words and computes the expected digest
// algorithmically; a negedge compare process checks every output each cycle.
// Known FIPS digests pin both the model and the DUT.
module tb_sha256_compress;

   localparam logic [255:0] IV_TB = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIGEST =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_BLOCK_DIGEST =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [31:0] KTAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clock = 1'b0;
   logic reset;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;
   int start_cyc    = 0;
   bit check_en     = 1'b0;

   logic [31:0] msg   [16];
   logic [31:0] sched [64];

   // Model state, advanced on every rising edge from the bus inputs only
   int           m_mode   = 0;
   int           m_count  = 0;
   logic         m_dv     = 1'b0;
   logic [255:0] m_digest = '0;
   logic [255:0] m_init   = '0;
   logic [31:0]  m_words [64];

   sha256_compress_if #(.W_LENGTH(64)) bus ();

   sha256_compress #(.W_LENGTH(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // 100 MHz free-running clock
   always #5 clock = ~clock;

   // Cycle counter used for latency measurement
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   // Straight-line SHA-256 compression over an array of eight working words
   function automatic logic [255:0] refCompress(input logic [255:0] init, input logic [31:0] w [64]);
      logic [31:0]  v [8];
      logic [31:0]  t1;
      logic [31:0]  t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = init[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                   + ((v[4] & v[5]) | (~v[4] & v[6])) + KTAB[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      r = '0;
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = init[255 - 32*i -: 32] + v[i];
      return r;
   endfunction

   task automatic clearMsg();
      for (int i = 0; i < 16; i++) msg[i] = '0;
   endtask

   task automatic expandSchedule();
      logic [31:0] s0;
      logic [31:0] s1;
      for (int t = 0; t < 16; t++) sched[t] = msg[t];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3);
         s1 = rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10);
         sched[t] = sched[t-16] + s0 + sched[t-7] + s1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Called at a negedge: drives start, then nwords schedule words with optional stalls and a stray start at word glitch_at
   task automatic applyStimulus(input logic [255:0] init, input int stall_pct,
                                input int glitch_at, input int nwords);
      int idx;
      int guard;
      idx   = 0;
      guard = 0;
      bus.start     = 1'b1;
      bus.init_hash = init;
      start_cyc     = cyc;
      @(negedge clock);
      bus.start = 1'b0;
      while (idx < nwords && guard < 4000) begin
         guard++;
         bus.start = (idx == glitch_at);
         if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
            bus.w_valid = 1'b0;
            bus.w_in    = $urandom;
         end else begin
            bus.w_valid = 1'b1;
            bus.w_in    = sched[idx];
            idx++;
         end
         @(negedge clock);
      end
      bus.start   = 1'b0;
      bus.w_valid = 1'b0;
      bus.w_in    = '0;
   endtask

   // Waits a bounded number of cycles for digest_valid; returns at the negedge where it is seen
   task automatic waitDigest(output logic [255:0] dig, output int lat);
      bit seen;
      seen = 1'b0;
      dig  = '0;
      lat  = -1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clock);
         if (bus.digest_valid === 1'b1) begin
            seen = 1'b1;
            dig  = bus.digest;
            lat  = cyc - start_cyc;
         end
      end
      if (!seen) checkOutput("digest_valid_timeout", 256'(0), 256'(1));
   endtask

   // Reference model: follows the block-level protocol and computes the digest once all words are in
   always @(posedge clock) begin
      if (!reset) begin
         m_mode   <= 0;
         m_count  <= 0;
         m_dv     <= 1'b0;
         m_digest <= '0;
      end else begin
         m_dv <= 1'b0;
         case (m_mode)
            0: if (bus.start) begin
               m_init  <= bus.init_hash;
               m_count <= 0;
               m_mode  <= 1;
            end
            1: if (bus.w_valid) begin
               m_words[m_count] <= bus.w_in;
               m_count          <= m_count + 1;
               if (m_count == 63) m_mode <= 2;
            end
            default: begin
               m_digest <= refCompress(m_init, m_words);
               m_dv     <= 1'b1;
               m_mode   <= 0;
            end
         endcase
      end
   end

   // Compare every DUT output against the model away from the active edge
   always @(negedge clock) begin
      if (check_en) begin
         checkOutput("busy",         256'(bus.busy),         256'(m_mode != 0));
         checkOutput("w_ready",      256'(bus.w_ready),      256'(m_mode == 1));
         checkOutput("round_index",  256'(bus.round_index),  256'(m_count % 64));
         checkOutput("digest_valid", 256'(bus.digest_valid), 256'(m_dv));
         checkOutput("digest",       bus.digest,             m_digest);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [255:0] dig;
      logic [255:0] dig1;
      logic [255:0] model1;
      int           lat;

      bus.start     = 1'b0;
      bus.init_hash = '0;
      bus.w_valid   = 1'b0;
      bus.w_in      = '0;
      reset         = 1'b0;
      repeat (3) @(negedge clock);
      check_en = 1'b1;

      $display("[TB] reset state");
      checkOutput("rst0_busy",         256'(bus.busy),         256'(0));
      checkOutput("rst0_w_ready",      256'(bus.w_ready),      256'(0));
      checkOutput("rst0_digest_valid", 256'(bus.digest_valid), 256'(0));
      checkOutput("rst0_round_index",  256'(bus.round_index),  256'(0));
      checkOutput("rst0_digest",       bus.digest,             256'(0));
      reset = 1'b1;
      @(negedge clock);

      $display("[TB] single block abc");
      clearMsg();
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      expandSchedule();
      checkOutput("model_abc", refCompress(IV_TB, sched), ABC_DIGEST);
      applyStimulus(IV_TB, 0, -1, 64);
      waitDigest(dig, lat);
      checkOutput("abc_digest",  dig,        ABC_DIGEST);
      checkOutput("abc_latency", 256'(lat),  256'(66));

      $display("[TB] empty message");
      clearMsg();
      msg[0] = 32'h80000000;
      expandSchedule();
      checkOutput("model_empty", refCompress(IV_TB, sched), EMPTY_DIGEST);
      repeat (2) @(negedge clock);
      applyStimulus(IV_TB, 0, -1, 64);
      waitDigest(dig, lat);
      checkOutput("empty_digest", dig, EMPTY_DIGEST);

      $display("[TB] abc with 50 percent stalls");
      clearMsg();
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      expandSchedule();
      @(negedge clock);
      applyStimulus(IV_TB, 50, -1, 64);
      waitDigest(dig, lat);
      checkOutput("stall_digest", dig, ABC_DIGEST);

      $display("[TB] reset after round 30");
      applyStimulus(IV_TB, 0, -1, 31);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midrst_busy",         256'(bus.busy),         256'(0));
      checkOutput("midrst_w_ready",      256'(bus.w_ready),      256'(0));
      checkOutput("midrst_digest_valid", 256'(bus.digest_valid), 256'(0));
      checkOutput("midrst_round_index",  256'(bus.round_index),  256'(0));
      checkOutput("midrst_digest",       bus.digest,             256'(0));
      reset = 1'b1;
      @(negedge clock);
      applyStimulus(IV_TB, 0, -1, 64);
      waitDigest(dig, lat);
      checkOutput("post_rst_digest", dig, ABC_DIGEST);

      $display("[TB] stray start at round 10, then back-to-back block");
      @(negedge clock);
      applyStimulus(IV_TB, 0, 10, 64);
      waitDigest(dig, lat);
      checkOutput("glitch_digest",  dig,       ABC_DIGEST);
      checkOutput("glitch_latency", 256'(lat), 256'(66));
      clearMsg();
      msg[0] = 32'h80000000;
      expandSchedule();
      applyStimulus(IV_TB, 0, -1, 64);
      waitDigest(dig, lat);
      checkOutput("b2b_digest",  dig,       EMPTY_DIGEST);
      checkOutput("b2b_latency", 256'(lat), 256'(66));

      $display("[TB] two-block chaining");
      clearMsg();
      msg[0]  = 32'h61626364; msg[1]  = 32'h62636465; msg[2]  = 32'h63646566;
      msg[3]  = 32'h64656667; msg[4]  = 32'h65666768; msg[5]  = 32'h66676869;
      msg[6]  = 32'h6768696a; msg[7]  = 32'h68696a6b; msg[8]  = 32'h696a6b6c;
      msg[9]  = 32'h6a6b6c6d; msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
      msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071; msg[14] = 32'h80000000;
      expandSchedule();
      model1 = refCompress(IV_TB, sched);
      @(negedge clock);
      applyStimulus(IV_TB, 0, -1, 64);
      waitDigest(dig1, lat);
      checkOutput("block1_digest", dig1, model1);
      clearMsg();
      msg[15] = 32'h000001c0;
      expandSchedule();
      checkOutput("model_two_block", refCompress(model1, sched), TWO_BLOCK_DIGEST);
      @(negedge clock);
      applyStimulus(dig1, 0, -1, 64);
      waitDigest(dig, lat);
      checkOutput("two_block_digest", dig, TWO_BLOCK_DIGEST);

      repeat (3) @(negedge clock);
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
